// File: rtl/ntt_butterfly_pe.sv
// ntt_butterfly_pe: CT/GS NTT butterfly with a bit-serial modular multiplier.
// Optional macro PE_INV_HALVE_EN halves both GS outputs mod q in POST.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

module ntt_butterfly_pe #(
    parameter int DATA_W = `DATA_SIZE_ARB
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] q,
    input  logic              mode,
    input  logic [DATA_W-1:0] data_top_i,
    input  logic [DATA_W-1:0] data_bot_i,
    input  logic [DATA_W-1:0] twiddle_i,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] ntt_top_o,
    output logic [DATA_W-1:0] ntt_bot_o,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef logic [DATA_W:0] wide_t;

    function automatic logic [DATA_W-1:0] mod_add(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] y,
        input logic [DATA_W-1:0] m
    );
        wide_t s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[DATA_W-1:0];
    endfunction

    // A borrow out of the extra bit means x < y; adding m back wraps into range.
    function automatic logic [DATA_W-1:0] mod_sub(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] y,
        input logic [DATA_W-1:0] m
    );
        wide_t d;
        d = {1'b0, x} - {1'b0, y};
        if (d[DATA_W])
            d = d + {1'b0, m};
        return d[DATA_W-1:0];
    endfunction

`ifdef PE_INV_HALVE_EN
    function automatic logic [DATA_W-1:0] mod_half(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] m
    );
        wide_t s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return s[DATA_W:1];
    endfunction
`endif

    logic [2:0]        state;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] w_r;
    logic              mode_r;
    logic [DATA_W-1:0] x_r;
    logic [DATA_W-1:0] sum_r;
    logic [DATA_W-1:0] acc_r;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] top_r;
    logic [DATA_W-1:0] bot_r;

    logic [DATA_W-1:0] acc_dbl;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0] post_top;
    logic [DATA_W-1:0] post_bot;

    always_comb begin
        acc_dbl = mod_add(acc_r, acc_r, q);
        acc_nxt = w_r[cnt] ? mod_add(acc_dbl, x_r, q) : acc_dbl;
    end

    always_comb begin
        post_top = mod_add(a_r, acc_r, q);
        post_bot = mod_sub(a_r, acc_r, q);
        if (mode_r) begin
`ifdef PE_INV_HALVE_EN
            post_top = mod_half(sum_r, q);
            post_bot = mod_half(acc_r, q);
`else
            post_top = sum_r;
            post_bot = acc_r;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            w_r    <= '0;
            mode_r <= 1'b0;
            x_r    <= '0;
            sum_r  <= '0;
            acc_r  <= '0;
            cnt    <= '0;
            top_r  <= '0;
            bot_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r    <= data_top_i;
                        b_r    <= data_bot_i;
                        w_r    <= twiddle_i;
                        mode_r <= mode;
                        state  <= S_PRE;
                    end
                end
                S_PRE: begin
                    sum_r <= mod_add(a_r, b_r, q);
                    x_r   <= mode_r ? mod_sub(a_r, b_r, q) : b_r;
                    acc_r <= '0;
                    cnt   <= CNT_W'(DATA_W - 1);
                    state <= S_MUL;
                end
                S_MUL: begin
                    acc_r <= acc_nxt;
                    if (cnt == '0)
                        state <= S_POST;
                    else
                        cnt <= cnt - 1'b1;
                end
                S_POST: begin
                    top_r <= post_top;
                    bot_r <= post_bot;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign ntt_top_o = top_r;
    assign ntt_bot_o = bot_r;

endmodule
